// File: rtl/line_memory_responder.sv
// Fixed-latency, line-granular backing memory answering whole-line reads and writes.
// One request in flight at a time; each request spends DELAY cycles in BUSY, then one in RESP.
module line_memory_responder #(
  parameter int LINE_SIZE = 16,
  parameter int NUM_LINES = 256,
  parameter int DELAY     = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_input_valid,
  input  logic [31:0]            addr,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [LINE_SIZE*8-1:0] din,
  output logic                   mem_ready,
  output logic                   is_output_valid,
  output logic [LINE_SIZE*8-1:0] dout
);
  localparam int OFF = $clog2(LINE_SIZE);
  localparam int IW  = $clog2(NUM_LINES);
  localparam int CW  = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   op_rd_q;
  logic [IW-1:0]          idx_q;
  logic [LINE_SIZE*8-1:0] din_q;
  logic                   ready_q;
  logic                   valid_q;
  logic [LINE_SIZE*8-1:0] dout_q;
  logic [LINE_SIZE*8-1:0] mem_q [NUM_LINES];

  logic          accept;
  logic          done;
  logic [IW-1:0] idx_d;
  logic          unused_addr;

  // Offset bits and index bits above the array depth are dropped, so high addresses alias.
  assign idx_d       = addr[OFF +: IW];
  assign unused_addr = ^{addr[31:OFF+IW], addr[OFF-1:0]};

  assign accept = (state_q == IDLE) && is_input_valid && (mem_read ^ mem_write);
  assign done   = (state_q == BUSY) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_rd_q <= 1'b0;
      idx_q   <= '0;
      din_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BUSY;
            cnt_q   <= CW'(DELAY - 1);
            op_rd_q <= mem_read;
            idx_q   <= idx_d;
            din_q   <= din;
            ready_q <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= RESP;
            valid_q <= op_rd_q;
            if (op_rd_q) dout_q <= mem_q[idx_q];
          end
        end
        RESP: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // An async reset clears state before the next edge, so an aborted write never reaches here.
  always_ff @(posedge clk) begin
    if (done && !op_rd_q) mem_q[idx_q] <= din_q;
  end

  assign mem_ready       = ready_q;
  assign is_output_valid = valid_q;
  assign dout            = dout_q;
endmodule
